fcs_checker: RTL and testbench

Parametrised Ethernet frame-check-sequence checker for the receive path. It consumes a nibble/dibit/byte stream framed by `data_valid` and runs a reflected CRC-32 over every beat, including the trailing 4-byte FCS. At each end of frame it reports CRC, alignment and length status plus the frame length, and keeps saturating good/bad frame counters. It sits between the PHY receive deserialiser and the frame buffer/packet parser, and its status is used to commit or drop the buffered frame.

---
 rtl/fcs_checker.sv | 128 ++++++++++++
 tb/tb_fcs_checker.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fcs_checker.sv
// rtl/fcs_checker.sv - receive-path Ethernet FCS checker with length/alignment status and frame counters
module fcs_checker #(
  parameter int          DATA_W  = 4,
  parameter logic [31:0] RESIDUE = 32'hDEBB20E3,
  parameter int          MIN_LEN = 64,
  parameter int          MAX_LEN = 1518,
  parameter int          LEN_W   = 11,
  parameter int          CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              status_valid,
  output logic              status_ok,
  output logic              status_crc_err,
  output logic              status_align_err,
  output logic              status_runt,
  output logic              status_giant,
  output logic [LEN_W-1:0]  frame_len,
  output logic [CNT_W-1:0]  good_cnt,
  output logic [CNT_W-1:0]  bad_cnt
);

  localparam int          SH       = $clog2(8 / DATA_W);
  localparam int          BW       = LEN_W + SH;
  localparam logic [31:0] POLY     = 32'hEDB88320;
  localparam logic [31:0] INIT     = 32'hFFFFFFFF;
  localparam logic [BW-1:0] REM_MASK = BW'((1 << SH) - 1);
  localparam logic [31:0] MIN_L    = 32'(MIN_LEN);
  localparam logic [31:0] MAX_L    = 32'(MAX_LEN);

  typedef enum logic [1:0] {IDLE, RX, SKIP} state_t;

  state_t          state, state_nxt;
  logic [31:0]     crc, crc_nxt;
  logic [BW-1:0]   beats, beats_nxt;
  logic            eof;
  logic [LEN_W-1:0] len_cur;
  logic            crc_bad, align_bad, runt, giant, frame_ok;

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [DATA_W-1:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < DATA_W; i++)
      r = (r >> 1) ^ (((r[0] ^ d[i]) != 1'b0) ? POLY : 32'h0);
    return r;
  endfunction

  // A saturated beat counter keeps frame_len pinned at all-ones after the shift.
  assign len_cur   = beats[BW-1:SH];
  assign crc_bad   = (crc != RESIDUE);
  assign align_bad = |(beats & REM_MASK);
  assign runt      = (32'(len_cur) < MIN_L);
  assign giant     = (32'(len_cur) > MAX_L);
  assign frame_ok  = !(crc_bad || align_bad || runt || giant);

  always_ff @(posedge clk) begin
    // Coming out of reset in SKIP drops a frame joined mid-stream; with data_valid low it falls to IDLE.
    if (!rst) state <= SKIP;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    crc_nxt   = crc;
    beats_nxt = beats;
    eof       = 1'b0;
    case (state)
      IDLE: begin
        if (data_valid) begin
          state_nxt = RX;
          crc_nxt   = crc_step(INIT, data_in);
          beats_nxt = BW'(1);
        end
      end
      RX: begin
        if (data_valid) begin
          crc_nxt   = crc_step(crc, data_in);
          beats_nxt = (beats == '1) ? beats : beats + 1'b1;
        end else begin
          eof       = 1'b1;
          state_nxt = IDLE;
          crc_nxt   = INIT;
          beats_nxt = '0;
        end
      end
      SKIP: begin
        if (!data_valid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      crc              <= INIT;
      beats            <= '0;
      status_valid     <= 1'b0;
      status_ok        <= 1'b0;
      status_crc_err   <= 1'b0;
      status_align_err <= 1'b0;
      status_runt      <= 1'b0;
      status_giant     <= 1'b0;
      frame_len        <= '0;
      good_cnt         <= '0;
      bad_cnt          <= '0;
    end else begin
      crc          <= crc_nxt;
      beats        <= beats_nxt;
      status_valid <= eof;
      if (eof) begin
        status_ok        <= frame_ok;
        status_crc_err   <= crc_bad;
        status_align_err <= align_bad;
        status_runt      <= runt;
        status_giant     <= giant;
        frame_len        <= len_cur;
        if (frame_ok) begin
          if (good_cnt != '1) good_cnt <= good_cnt + 1'b1;
        end else begin
          if (bad_cnt != '1) bad_cnt <= bad_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fcs_checker.sv
// tb/tb_fcs_checker.sv - self-checking bench for fcs_checker at DATA_W 4, 8 and 2
module tb_fcs_checker;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] d4 = '0;
  logic [7:0] d8 = '0;
  logic [1:0] d2 = '0;
  logic v4 = 1'b0, v8 = 1'b0, v2 = 1'b0;

  logic        sv[3], okv[3], ce[3], ae[3], ru[3], gi[3];
  logic [10:0] ln[3];
  logic [15:0] gc[3], bc[3];
  logic [15:0] gc4, bc4, gc2, bc2;
  logic [1:0]  gc8, bc8;

  assign gc[0] = gc4;            assign bc[0] = bc4;
  assign gc[1] = {14'b0, gc8};   assign bc[1] = {14'b0, bc8};
  assign gc[2] = gc2;            assign bc[2] = bc2;

  fcs_checker #(.DATA_W(4)) u4 (
    .clk(clk), .rst(rst), .data_in(d4), .data_valid(v4),
    .status_valid(sv[0]), .status_ok(okv[0]), .status_crc_err(ce[0]), .status_align_err(ae[0]),
    .status_runt(ru[0]), .status_giant(gi[0]), .frame_len(ln[0]), .good_cnt(gc4), .bad_cnt(bc4));

  fcs_checker #(.DATA_W(8), .CNT_W(2)) u8 (
    .clk(clk), .rst(rst), .data_in(d8), .data_valid(v8),
    .status_valid(sv[1]), .status_ok(okv[1]), .status_crc_err(ce[1]), .status_align_err(ae[1]),
    .status_runt(ru[1]), .status_giant(gi[1]), .frame_len(ln[1]), .good_cnt(gc8), .bad_cnt(bc8));

  fcs_checker #(.DATA_W(2)) u2 (
    .clk(clk), .rst(rst), .data_in(d2), .data_valid(v2),
    .status_valid(sv[2]), .status_ok(okv[2]), .status_crc_err(ce[2]), .status_align_err(ae[2]),
    .status_runt(ru[2]), .status_giant(gi[2]), .frame_len(ln[2]), .good_cnt(gc2), .bad_cnt(bc2));

  typedef struct packed {
    int          cyc;
    logic        ok, crc, align, runt, giant;
    logic [10:0] len;
    logic [15:0] good, bad;
  } rec_t;

  rec_t mq[3][$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   eg[3] = '{0, 0, 0};
  int   eb[3] = '{0, 0, 0};
  int   cmax[3] = '{65535, 3, 65535};
  bit   fr[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    for (int k = 0; k < 3; k++)
      if (sv[k] === 1'b1)
        mq[k].push_back('{cyc, okv[k], ce[k], ae[k], ru[k], gi[k], ln[k], gc[k], bc[k]});

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference CRC: bit-serial reflected CRC-32 over the first n bits of the frame, in wire order.
  function automatic logic [31:0] crc_over(input int n);
    logic [31:0] c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++)
      c = ((c[0] ^ fr[i]) != 1'b0) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  task automatic add_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) fr.push_back(b[i]);
  endtask

  task automatic add_fcs();
    logic [31:0] f;
    f = ~crc_over(fr.size());
    add_byte(f[7:0]); add_byte(f[15:8]); add_byte(f[23:16]); add_byte(f[31:24]);
  endtask

  task automatic build_rand(input int nbytes);
    fr.delete();
    for (int i = 0; i < nbytes - 4; i++) add_byte(8'($urandom));
    add_fcs();
  endtask

  task automatic build_zero();
    fr.delete();
    for (int i = 0; i < 60; i++) add_byte(8'h00);
    add_byte(8'h1C); add_byte(8'hDF); add_byte(8'h44); add_byte(8'h21);
  endtask

  task automatic send(input int k, input int rst_beat, output int last);
    int w, nb;
    w  = (k == 0) ? 4 : ((k == 1) ? 8 : 2);
    nb = fr.size() / w;
    last = 0;
    for (int b = 0; b < nb; b++) begin
      @(posedge clk); #1;
      rst = (b == rst_beat) ? 1'b0 : 1'b1;
      for (int j = 0; j < w; j++)
        case (k)
          0: d4[j] = fr[b*w+j];
          1: d8[j] = fr[b*w+j];
          default: d2[j] = fr[b*w+j];
        endcase
      case (k)
        0: v4 = 1'b1;
        1: v8 = 1'b1;
        default: v2 = 1'b1;
      endcase
      last = cyc;
    end
    @(posedge clk); #1;
    rst = 1'b1;
    v4 = 1'b0; v8 = 1'b0; v2 = 1'b0;
    if (rst_beat >= 0)
      for (int i = 0; i < 3; i++) begin eg[i] = 0; eb[i] = 0; end
  endtask

  task automatic expect_frame(input string tag, input int k, input int last, output int pcyc);
    int n, len, t;
    bit al, rn, gn, cr, good;
    rec_t r;
    n    = fr.size();
    len  = (n / 8 > 2047) ? 2047 : n / 8;
    al   = (n % 8) != 0;
    rn   = len < 64;
    gn   = len > 1518;
    cr   = crc_over(n) != 32'hDEBB20E3;
    good = !(al || rn || gn || cr);
    if (good) eg[k] = (eg[k] < cmax[k]) ? eg[k] + 1 : eg[k];
    else      eb[k] = (eb[k] < cmax[k]) ? eb[k] + 1 : eb[k];
    pcyc = 0;
    t = 0;
    while (mq[k].size() == 0 && t < 20) begin @(negedge clk); t++; end
    chk({tag, ".pulse"}, 64'(mq[k].size() != 0), 64'd1);
    if (mq[k].size() != 0) begin
      r = mq[k].pop_front();
      pcyc = r.cyc;
      chk({tag, ".latency"}, 64'(r.cyc - last), 64'd2);
      chk({tag, ".ok"},      64'(r.ok),    64'(good));
      chk({tag, ".crc_err"}, 64'(r.crc),   64'(cr));
      chk({tag, ".align"},   64'(r.align), 64'(al));
      chk({tag, ".runt"},    64'(r.runt),  64'(rn));
      chk({tag, ".giant"},   64'(r.giant), 64'(gn));
      chk({tag, ".len"},     64'(r.len),   64'(len));
      chk({tag, ".good"},    64'(r.good),  64'(eg[k]));
      chk({tag, ".bad"},     64'(r.bad),   64'(eb[k]));
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int last, last2, p1, p2, nb;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++)
      chk($sformatf("reset_outputs%0d", k),
          {sv[k], okv[k], ce[k], ae[k], ru[k], gi[k], ln[k], gc[k], bc[k]}, 64'd0);
    @(posedge clk); #1 rst = 1'b1;
    idle(3);

    build_zero();
    send(0, -1, last); expect_frame("zero_good", 0, last, p1);

    fr[10*8+3] = ~fr[10*8+3];
    send(0, -1, last); expect_frame("bitflip", 0, last, p1);

    build_zero();
    for (int i = 0; i < 4; i++) fr.push_back(1'($urandom));
    send(0, -1, last); expect_frame("extra_nibble", 0, last, p1);

    build_rand(63);   send(0, -1, last); expect_frame("len63", 0, last, p1);
    build_rand(64);   send(0, -1, last); expect_frame("len64", 0, last, p1);
    build_rand(1518); send(0, -1, last); expect_frame("len1518", 0, last, p1);
    build_rand(1519); send(0, -1, last); expect_frame("len1519", 0, last, p1);

    build_zero();
    send(0, -1, last); send(0, -1, last2);
    expect_frame("b2b_a", 0, last, p1);
    expect_frame("b2b_b", 0, last2, p2);
    chk("b2b_gap", 64'(p2 - p1), 64'd129);

    fr.delete();
    for (int i = 0; i < 4; i++) fr.push_back(1'($urandom));
    send(0, -1, last); expect_frame("one_beat", 0, last, p1);

    for (int i = 0; i < 8; i++) begin
      build_rand($urandom_range(60, 140));
      if ($urandom_range(0, 2) == 0) begin
        nb = $urandom_range(0, fr.size() - 1);
        fr[nb] = ~fr[nb];
      end
      if ($urandom_range(0, 3) == 0)
        for (int j = 0; j < 4; j++) fr.push_back(1'($urandom));
      send(0, -1, last); expect_frame($sformatf("rand%0d", i), 0, last, p1);
    end

    build_zero();
    send(0, 40, last);
    idle(6);
    chk("reset_midframe_nopulse", 64'(mq[0].size()), 64'd0);
    send(0, -1, last); expect_frame("after_reset", 0, last, p1);

    build_zero();
    send(1, -1, last); expect_frame("w8_zero", 1, last, p1);
    send(2, -1, last); expect_frame("w2_zero", 2, last, p1);
    for (int i = 0; i < 4; i++) begin
      fr.delete(); add_byte(8'($urandom));
      send(1, -1, last); expect_frame($sformatf("w8_sat%0d", i), 1, last, p1);
    end
    build_rand(2050);
    send(1, -1, last); expect_frame("w8_lensat", 1, last, p1);
    build_rand(100);
    send(2, -1, last); expect_frame("w2_rand", 2, last, p1);

    idle(4);
    for (int k = 0; k < 3; k++)
      chk($sformatf("no_extra_pulse%0d", k), 64'(mq[k].size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
